prog_ctr_fetch: RTL and testbench
=================================

// Module: prog_ctr_fetch
// PURPOSE
//  Program-counter / fetch-control stage sitting directly upstream of the instruction ROM.
//  Holds the PC, drives prog_ctr into the ROM each cycle and advances it by +1, relative branch or absolute jump.
//  Sequences program start/halt and counts executed instructions for the testbench/done handshake.
// PARAMETERS
//  D      12  PC width; must match the instruction ROM address width (ROM depth 2**D)
//  OFS_W  8   width of signed relative-branch offset
//  CNT_W  16  width of executed-instruction counter
// PORTS
//  clk           in   1      single system clock; all state updates on rising edge
//  reset         in   1      synchronous, active-high reset
//  start         in   1      pulse: begin execution at start_addr (honoured only in IDLE/HALTED)
//  start_addr    in   D      first PC of program, sampled when start accepted
//  stall         in   1      hold PC this cycle (RUN only)
//  halt          in   1      decoder flags current instruction as HALT
//  jump_abs      in   1      absolute jump to target this cycle
//  target        in   D      absolute jump target (from jump LUT)
//  rel_branch    in   1      current instruction is a relative branch
//  branch_taken  in   1      branch condition true (qualifies rel_branch)
//  rel_offset    in   OFS_W  signed two's-complement branch offset
//  prog_ctr      out  D      current PC, drives ROM address
//  running       out  1      high in RUN
//  done          out  1      high (level) in HALTED
//  instr_count   out  CNT_W  instructions executed since last accepted start
// BEHAVIOUR
//  - Reset (sync, active-high, wins over all): state=IDLE, prog_ctr=0, running=0, done=0, instr_count=0.
//  - States: IDLE, RUN, HALTED. running/done are registered decodes of state (no comb glitches).
//  - IDLE/HALTED: start=1 -> next cycle state=RUN, prog_ctr=start_addr, instr_count=0, done=0.
//    start=0 -> all registers hold. stall/halt/jump/branch inputs ignored.
//  - RUN, per cycle, priority highest first:
//    1. halt=1     -> state=HALTED, prog_ctr holds, instr_count+1 (HALT counts as executed).
//    2. stall=1    -> prog_ctr and instr_count hold.
//    3. jump_abs=1 -> prog_ctr=target.
//    4. rel_branch & branch_taken -> prog_ctr = prog_ctr + sign_extend(rel_offset).
//    5. else       -> prog_ctr = prog_ctr + 1.
//    Cases 3-5 increment instr_count.
//  - start asserted while RUN is ignored; no restart mid-program.
//  - Arithmetic: PC update is modulo 2**D. 2**D-1 + 1 wraps to 0. Negative offsets wrap below 0.
//    rel_offset sign-extended to D bits before add. OFS_W > D is illegal.
//  - rel_branch with branch_taken=0 falls to +1. jump_abs with rel_branch: jump wins.
//  - instr_count saturates at 2**CNT_W-1; never wraps.
//  - Latency: prog_ctr changes one cycle after the qualifying input. ROM read is combinational.
//    The instruction at prog_ctr is therefore visible the same cycle. Control inputs refer to that instruction.
//  - Reset mid-RUN: next cycle IDLE with all outputs at reset values. No partial-update state survives.
// TESTING
//  1. Reset then start with start_addr=0, no control for 5 cycles -> prog_ctr 0,1,2,3,4,5; running=1; instr_count=5.
//  2. In RUN at PC=10: rel_offset=-3 (8'hFD), branch_taken=1 -> PC=7.
//     Same at PC=1 -> PC=2**D-2 (wrap). branch_taken=0 -> PC+1.
//  3. PC=20, jump_abs=1, target=300 with rel_branch&taken also high -> PC=300. Then stall 3 cycles -> PC stays 300, count unchanged.
//  4. halt=1 together with stall=1 at PC=42 -> HALTED, done=1, running=0, PC=42, count+1.
//     Then start with start_addr=5 -> RUN, PC=5, count=0, done=0.
//  5. PC=2**D-1, no control -> PC=0. start pulses during RUN -> no effect on PC or count.
//  6. Assert reset mid-RUN with stall and jump_abs also high -> next cycle IDLE, PC=0, running=0, done=0, count=0.

Source files
------------

// File: rtl/prog_ctr_fetch_if.sv
// prog_ctr_fetch_if: control/fetch bus between decoder, testbench and the PC stage
interface prog_ctr_fetch_if #(
    parameter int D     = 12,
    parameter int OFS_W = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic [D-1:0]     start_addr;
    logic             stall;
    logic             halt;
    logic             jump_abs;
    logic [D-1:0]     target;
    logic             rel_branch;
    logic             branch_taken;
    logic [OFS_W-1:0] rel_offset;
    logic [D-1:0]     prog_ctr;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output start, start_addr, stall, halt, jump_abs, target, rel_branch, branch_taken, rel_offset,
        input  prog_ctr, running, done, instr_count
    );
    modport slave (
        input  start, start_addr, stall, halt, jump_abs, target, rel_branch, branch_taken, rel_offset,
        output prog_ctr, running, done, instr_count
    );
endinterface

// File: rtl/prog_ctr_fetch.sv
// prog_ctr_fetch: program counter with start/halt sequencing and saturating executed-instruction count
module prog_ctr_fetch #(
    parameter int D     = 12,
    parameter int OFS_W = 8,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             reset,
    prog_ctr_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t           state, state_nxt;
    logic [D-1:0]     pc, pc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             inc;
    logic             running, done;
    logic [D-1:0]     ofs_ext;

    assign ofs_ext = D'($signed(bus.rel_offset));

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        inc       = 1'b0;
        if (state != RUN) begin
            if (bus.start) begin
                state_nxt = RUN;
                pc_nxt    = bus.start_addr;
                cnt_nxt   = '0;
            end
        end else if (bus.halt) begin
            state_nxt = HALTED;
            inc       = 1'b1;
        end else if (!bus.stall) begin
            inc    = 1'b1;
            pc_nxt = bus.jump_abs                     ? bus.target :
                     bus.rel_branch && bus.branch_taken ? pc + ofs_ext :
                                                          pc + D'(1);
        end
        // counter sticks at all-ones instead of wrapping
        if (inc && cnt != '1)
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            cnt     <= cnt_nxt;
            running <= state_nxt == RUN;
            done    <= state_nxt == HALTED;
        end
    end

    assign bus.prog_ctr    = pc;
    assign bus.running     = running;
    assign bus.done        = done;
    assign bus.instr_count = cnt;
endmodule

// File: tb/tb_prog_ctr_fetch.sv
// tb_prog_ctr_fetch: directed vector table plus hand-written wrap/restart sequence
module tb_prog_ctr_fetch;
    localparam int D = 12, OFS_W = 8, CNT_W = 4;

    typedef struct {
        logic        rst, st;
        logic [11:0] sa;
        logic        stl, hlt, jmp;
        logic [11:0] tgt;
        logic        rb, bt;
        logic [7:0]  ofs;
        logic [11:0] pc;
        logic        run, dn;
        logic [3:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prog_ctr_fetch_if #(.D(D), .OFS_W(OFS_W), .CNT_W(CNT_W)) bus ();
    prog_ctr_fetch #(.D(D), .OFS_W(OFS_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0, errors = 0;
    vec_t tbl[$];

    function automatic vec_t v(input logic rst, st, input logic [11:0] sa, input logic stl, hlt, jmp,
                               input logic [11:0] tgt, input logic rb, bt, input logic [7:0] ofs,
                               input logic [11:0] pc, input logic run, dn, input logic [3:0] cnt);
        vec_t r;
        r.rst = rst; r.st = st; r.sa = sa; r.stl = stl; r.hlt = hlt; r.jmp = jmp; r.tgt = tgt;
        r.rb = rb; r.bt = bt; r.ofs = ofs; r.pc = pc; r.run = run; r.dn = dn; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input int idx);
        reset = x.rst; bus.start = x.st; bus.start_addr = x.sa; bus.stall = x.stl; bus.halt = x.hlt;
        bus.jump_abs = x.jmp; bus.target = x.tgt; bus.rel_branch = x.rb; bus.branch_taken = x.bt;
        bus.rel_offset = x.ofs;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d prog_ctr", idx), 32'(bus.prog_ctr), 32'(x.pc));
        chk($sformatf("v%0d running", idx), 32'(bus.running), 32'(x.run));
        chk($sformatf("v%0d done", idx), 32'(bus.done), 32'(x.dn));
        chk($sformatf("v%0d instr_count", idx), 32'(bus.instr_count), 32'(x.cnt));
    endtask

    initial begin
        //                 rst st sa     stl hlt jmp tgt    rb bt ofs     pc     run dn cnt
        tbl.push_back(v(1, 0, 0,     0, 0, 0, 0,     0, 0, 0,     0,     0, 0, 0));
        tbl.push_back(v(0, 0, 0,     1, 1, 1, 9,     1, 1, 3,     0,     0, 0, 0));
        tbl.push_back(v(0, 1, 0,     0, 0, 0, 0,     0, 0, 0,     0,     1, 0, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'(i), 1, 0, 4'(i)));
        tbl.push_back(v(0, 0, 0,     0, 0, 1, 42,    0, 0, 0,     42,    1, 0, 6));
        tbl.push_back(v(0, 0, 0,     1, 1, 0, 0,     0, 0, 0,     42,    0, 1, 7));
        tbl.push_back(v(0, 0, 0,     1, 1, 1, 9,     1, 1, 3,     42,    0, 1, 7));
        tbl.push_back(v(0, 1, 5,     0, 0, 0, 0,     0, 0, 0,     5,     1, 0, 0));
        tbl.push_back(v(0, 0, 0,     0, 0, 1, 10,    0, 0, 0,     10,    1, 0, 1));
        tbl.push_back(v(0, 0, 0,     0, 0, 0, 0,     1, 1, 8'hFD, 7,     1, 0, 2));
        tbl.push_back(v(0, 0, 0,     0, 0, 1, 1,     0, 0, 0,     1,     1, 0, 3));
        tbl.push_back(v(0, 0, 0,     0, 0, 0, 0,     1, 1, 8'hFD, 4094,  1, 0, 4));
        tbl.push_back(v(0, 0, 0,     0, 0, 0, 0,     1, 0, 8'hFD, 4095,  1, 0, 5));
        tbl.push_back(v(0, 0, 0,     0, 0, 0, 0,     0, 0, 0,     0,     1, 0, 6));
        tbl.push_back(v(0, 1, 77,    0, 0, 0, 0,     0, 0, 0,     1,     1, 0, 7));
        tbl.push_back(v(0, 0, 0,     0, 0, 1, 20,    0, 0, 0,     20,    1, 0, 8));
        tbl.push_back(v(0, 0, 0,     0, 0, 1, 300,   1, 1, 5,     300,   1, 0, 9));
        tbl.push_back(v(0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     300,   1, 0, 9));
        tbl.push_back(v(0, 0, 0,     1, 0, 1, 9,     1, 1, 5,     300,   1, 0, 9));
        tbl.push_back(v(0, 1, 3,     1, 0, 0, 0,     0, 0, 0,     300,   1, 0, 9));
        for (int i = 1; i <= 7; i++)
            tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'(300 + i), 1, 0, (i >= 6) ? 4'd15 : 4'(9 + i)));
        tbl.push_back(v(1, 0, 0,     1, 0, 1, 99,    0, 0, 0,     0,     0, 0, 0));
        tbl.push_back(v(0, 0, 0,     1, 0, 1, 99,    0, 0, 0,     0,     0, 0, 0));
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // restart near the top of the address space, wrap, halt, then restart from HALTED
        apply(v(0, 1, 4093, 0, 0, 0, 0, 0, 0, 0, 4093, 1, 0, 0), 100);
        apply(v(0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 4094, 1, 0, 1), 101);
        apply(v(0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 4095, 1, 0, 2), 102);
        apply(v(0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 3), 103);
        apply(v(0, 0, 0,    0, 0, 0, 0, 1, 1, 8'h80, 3968, 1, 0, 4), 104);
        apply(v(0, 0, 0,    0, 1, 1, 7, 0, 0, 0, 3968, 0, 1, 5), 105);
        apply(v(0, 1, 11,   0, 1, 1, 7, 0, 0, 0, 11,   1, 0, 0), 106);
        apply(v(0, 0, 0,    0, 1, 0, 0, 0, 0, 0, 11,   0, 1, 1), 107);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
